// File: rtl/au_pkg.sv
// Shared definitions for the AU sequencer: opcode map, FSM encoding, default width.
package au_pkg;

    localparam int AU_W = 8;

    localparam logic [3:0] OP_LDA  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_MOVA = 4'b0100;
    localparam logic [3:0] OP_MOVB = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_OUT  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_OWAIT = 2'd2
    } state_t;

    // Opcodes that need an execute cycle on the AU.
    function automatic logic is_au_op(input logic [3:0] op);
        return (op == OP_MOVA) || (op == OP_MOVB) || (op == OP_ADD) ||
               (op == OP_SUB)  || (op == OP_OUT);
    endfunction

endpackage

// File: rtl/au_seq_if.sv
// Instruction-in and result-out handshake channels of the AU sequencer.
interface au_seq_if #(parameter int W = 8);
    logic         ins_valid;
    logic         ins_ready;
    logic [7:0]   ins;
    logic [W-1:0] din;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output ins_valid, ins, din, out_ready,
        input  ins_ready, out_data, out_valid
    );

    modport slave (
        input  ins_valid, ins, din, out_ready,
        output ins_ready, out_data, out_valid
    );
endinterface

// File: rtl/au_seq.sv
// Sequencer for the combinational AU: owns A/B/G, issues one EXEC cycle per
// AU instruction and forwards OUT results through a valid/ready port.
module au_seq
    import au_pkg::*;
#(
    parameter int W = AU_W
) (
    input  logic         clk,
    input  logic         rst,
    au_seq_if.slave      bus,
    output logic         au_en,
    output logic [3:0]   ac,
    output logic [W-1:0] au_a,
    output logic [W-1:0] au_b,
    input  logic [W-1:0] au_t,
    input  logic         au_gf,
    output logic [W-1:0] reg_a,
    output logic [W-1:0] reg_b,
    output logic         g_flag,
    output logic         err
);

    state_t       state_q, state_n;
    logic [3:0]   op_q;
    logic [W-1:0] a_q, b_q, out_q;
    logic         g_q, err_q;

    logic [3:0]   opcode;
    logic         ins_ready_c, out_valid_c;
    logic         ins_take;
    logic         unused_ins_lo;

    assign opcode        = bus.ins[7:4];
    assign unused_ins_lo = ^bus.ins[3:0];
    assign ins_take      = (state_q == S_IDLE) && bus.ins_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    // Operands come straight from registered state so they are stable for the whole EXEC cycle.
    always_comb begin
        state_n     = state_q;
        ins_ready_c = 1'b0;
        out_valid_c = 1'b0;
        au_en       = 1'b0;
        ac          = 4'b0000;
        au_a        = a_q;
        au_b        = b_q;
        case (state_q)
            S_IDLE: begin
                ins_ready_c = !rst;
                if (bus.ins_valid && is_au_op(opcode)) state_n = S_EXEC;
            end
            S_EXEC: begin
                au_en = 1'b1;
                ac    = op_q;
                if (op_q == OP_MOVB) au_a = b_q;
                state_n = (op_q == OP_OUT) ? S_OWAIT : S_IDLE;
            end
            S_OWAIT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            g_q   <= 1'b0;
            out_q <= '0;
            op_q  <= 4'b0000;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (ins_take) begin
                case (opcode)
                    OP_LDA:  a_q <= bus.din;
                    OP_LDB:  b_q <= bus.din;
                    OP_MOVA, OP_MOVB, OP_ADD, OP_SUB, OP_OUT: op_q <= opcode;
                    default: err_q <= 1'b1;
                endcase
            end
            // Writeback: au_t is only meaningful while au_en is high.
            if (state_q == S_EXEC) begin
                case (op_q)
                    OP_MOVA: b_q <= au_t;
                    OP_MOVB, OP_ADD: a_q <= au_t;
                    OP_SUB: begin
                        a_q <= au_t;
                        g_q <= au_gf;
                    end
                    OP_OUT:  out_q <= au_t;
                    default: ;
                endcase
            end
        end
    end

    assign bus.ins_ready = ins_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_q;
    assign reg_a         = a_q;
    assign reg_b         = b_q;
    assign g_flag        = g_q;
    assign err           = err_q;

endmodule
